// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// bit-counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // At least one bit wide, so WIDTH=1 still has a legal (constant-zero) counter.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_1bit.sv
// Single-bit full adder built from two half adders; the one shared arithmetic
// resource of the serial adder.
module ha_1bit (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module fa_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s0, c0, c1;

  ha_1bit u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
  ha_1bit u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

  assign c_o = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts operands, walks one shared full adder
// over the bits LSB-first, then presents {cout,sum} until the consumer takes it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, s_sr_d;
  logic             c_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             fa_s, fa_c;

  fa_1bit u_fa (
    .a_i(a_sr_q[0]),
    .b_i(b_sr_q[0]),
    .c_i(c_q),
    .s_o(fa_s),
    .c_o(fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  if (WIDTH == 1) begin : g_s1
    assign s_sr_d = fa_s;
  end else begin : g_sn
    assign s_sr_d = {fa_s, s_sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      s_sr_q      <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sr_q     <= a;
            b_sr_q     <= b;
            c_q        <= cin;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          s_sr_q <= s_sr_d;
          c_q    <= fa_c;
          // Counter holds on the exit edge so it never wraps.
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            cout_q      <= fa_c;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = s_sr_q;
  assign cout      = cout_q;

endmodule
